vend_change_fsm: RTL

Parametrised vending controller that accumulates coin credit, dispenses one item when credit reaches a programmable price, and pays change (or a cancel refund) one coin at a time over a strobe/acknowledge handshake to the coin hopper. It replaces the fixed nine-state decode with a credit register of configurable width and price. It drives the item solenoid and the half-farthing-pair / farthing change strobes, and exports the running credit for the existing seven-segment display path.

---
 rtl/vend_change_fsm_if.sv | 29 ++
 rtl/vend_change_fsm.sv | 99 +++++++++
 2 files changed

// File: rtl/vend_change_fsm_if.sv
`default_nettype none
// vend_change_fsm_if: coin slots, hopper handshake and status outputs of the vending controller.
// Revision 1.0
interface vend_change_fsm_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_q;
  logic                coin_h;
  logic                coin_p;
  logic                cancel;
  logic                chg_ack;
  logic                item;
  logic                h_change;
  logic                q_change;
  logic                busy;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin_q, coin_h, coin_p, cancel, chg_ack,
    input  item, h_change, q_change, busy, coin_reject, credit
  );

  modport slave (
    input  coin_q, coin_h, coin_p, cancel, chg_ack,
    output item, h_change, q_change, busy, coin_reject, credit
  );
endinterface
`default_nettype wire

// File: rtl/vend_change_fsm.sv
`default_nettype none
// vend_change_fsm: credit accumulator, single-item vend and greedy coin-at-a-time change payout.
// Revision 1.0
module vend_change_fsm #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  vend_change_fsm_if.slave  bus
);
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] VEND    = 2'd1;
  localparam logic [1:0] CHANGE  = 2'd2;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  // Headroom for a full 7-farthing handful on top of PRICE-1 credit.
  generate
    if (PRICE < 1 || (PRICE + 6) > ((2 ** CREDIT_W) - 1)) begin : g_bad_params
      $fatal(1, "vend_change_fsm: PRICE/CREDIT_W combination cannot hold maximum credit");
    end
  endgenerate

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nx;
  logic                reject;
  logic                reject_nx;
  logic [2:0]          inc;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] pay;

  // Coin weights 4/2/1 line up with a plain binary encoding.
  assign inc = {bus.coin_p, bus.coin_h, bus.coin_q};
  assign sum = credit + CREDIT_W'(inc);
  assign pay = (credit >= TWO_C) ? TWO_C : ONE_C;

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    reject_nx = (inc != 3'd0);
    case (state)
      COLLECT: begin
        if (bus.cancel) begin
          if (credit != '0) begin
            state_nx = CHANGE;
          end
        end else begin
          reject_nx = 1'b0;
          if (sum >= PRICE_C) begin
            state_nx  = VEND;
            credit_nx = sum - PRICE_C;
          end else begin
            credit_nx = sum;
          end
        end
      end
      VEND: begin
        state_nx = (credit == '0) ? COLLECT : CHANGE;
      end
      CHANGE: begin
        if (bus.chg_ack) begin
          credit_nx = credit - pay;
          if (credit == pay) begin
            state_nx = COLLECT;
          end
        end
      end
      default: begin
        state_nx  = COLLECT;
        credit_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= COLLECT;
      credit <= '0;
      reject <= 1'b0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
      reject <= reject_nx;
    end
  end

  assign bus.item        = (state == VEND);
  assign bus.busy        = (state != COLLECT);
  assign bus.h_change    = (state == CHANGE) && (credit >= TWO_C);
  assign bus.q_change    = (state == CHANGE) && (credit == ONE_C);
  assign bus.coin_reject = reject;
  assign bus.credit      = credit;
endmodule
`default_nettype wire
